// File: rtl/fib_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// fib_pkg : state encoding and default widths for the step controller
// Rev 1.0
// ----------------------------------------------------------------
package fib_pkg;

  localparam int c_DEF_X = 20;
  localparam int c_DEF_W = 3;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2,
    HALT   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fib_step_controller_tick_prescaler.sv
`default_nettype none
// ----------------------------------------------------------------
// tick_prescaler : X-bit free-running counter, one-cycle tick on wrap
// Rev 1.0
// ----------------------------------------------------------------
module tick_prescaler
  import fib_pkg::*;
#(
  parameter int X = c_DEF_X
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  logic [X-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Carry out of the counter: only meaningful while it is counting.
  assign o_tick = i_en & (&r_cnt);

endmodule
`default_nettype wire

// File: rtl/fib_step_controller.sv
`default_nettype none
// ----------------------------------------------------------------
// fib_step_controller : single-clock step/clear sequencer for the Fibonacci counters
// Rev 1.0
// ----------------------------------------------------------------
module fib_step_controller
  import fib_pkg::*;
#(
  parameter int X = c_DEF_X,
  parameter int W = c_DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_but_pulse,
  input  logic         i_rst_req,
  input  logic         i_auto_en,
  input  logic [W-1:0] i_div,
  input  logic         i_fib_ovf,
  output logic         o_step,
  output logic         o_clr,
  output logic [1:0]   o_state
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_auto_q;
  logic         r_pause;
  logic         r_step;
  logic [W-1:0] r_per;
  logic [W-1:0] r_div;
  logic         w_step_nxt;
  logic         w_pause_nxt;
  logic         w_tick;
  logic         w_edge;
  logic         w_abort;
  logic         w_is_clear;
  logic         w_presc_en;
  logic         w_wrap;

  assign w_edge     = i_auto_en ^ r_auto_q;
  assign w_abort    = i_rst_req | w_edge;
  assign w_is_clear = (r_state == CLEAR);
  assign w_presc_en = (r_state == AUTO) & ~r_pause;
  assign w_wrap     = w_tick & (r_per == r_div);

  tick_prescaler #(
    .X(X)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_presc_en),
    .i_clr  (w_is_clear),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = 1'b0;
    w_pause_nxt = r_pause;
    case (r_state)
      CLEAR: begin
        w_state_nxt = i_auto_en ? AUTO : MANUAL;
        w_pause_nxt = 1'b0;
      end
      MANUAL: begin
        if (!w_abort && i_but_pulse) begin
          if (i_fib_ovf) w_state_nxt = HALT;
          else           w_step_nxt  = 1'b1;
        end
      end
      AUTO: begin
        if (!w_abort) begin
          if (i_but_pulse) w_pause_nxt = ~r_pause;
          if (w_wrap) begin
            if (i_fib_ovf) w_state_nxt = HALT;
            else           w_step_nxt  = 1'b1;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
    // CLEAR already re-reads auto_en, so an edge there needs no extra visit.
    if (i_rst_req) begin
      w_state_nxt = CLEAR;
    end else if (w_edge && !w_is_clear) begin
      w_state_nxt = CLEAR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= CLEAR;
      r_step   <= 1'b0;
      r_pause  <= 1'b0;
      r_auto_q <= i_auto_en;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_pause  <= w_pause_nxt;
      r_auto_q <= i_auto_en;
    end
  end

  // Period counter; div is captured at every wrap so a new value applies from the next period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_per <= '0;
      r_div <= '0;
    end else if (w_is_clear) begin
      r_per <= '0;
      r_div <= i_div;
    end else if (w_tick) begin
      if (r_per == r_div) begin
        r_per <= '0;
        r_div <= i_div;
      end else begin
        r_per <= r_per + 1'b1;
      end
    end
  end

  assign o_step  = r_step;
  assign o_clr   = w_is_clear;
  assign o_state = r_state;

endmodule
`default_nettype wire

// File: doc/fib_step_controller.md
# fib_step_controller

Clock-enable sequencer for the Fibonacci/click counter datapath. It replaces the derived-clock stepping and the ad-hoc mode-change reset with a single-clock state machine. It takes the debounced manual click, the auto-click enable and divider switches, the user reset pulse and the Fibonacci overflow flag, and issues one-cycle `step` enables and `clr` pulses to `counter` and `fib_counter`. It sits between the clicker/DIP-switch inputs and the counters, in the fast `clk` domain.

## Interface
- `X`, default 20: prescaler width; one base tick every 2^X `clk` cycles.
- `W`, default 3: width of the `div` input.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `but_pulse` input 1: debounced manual click, one cycle wide.
- `rst_req` input 1: debounced user reset, one cycle wide.
- `auto_en` input 1: level; 1 selects auto-click mode. Treated as already synchronous to `clk`.
- `div` input W: auto period select; period = (div+1)·2^X cycles.
- `fib_ovf` input 1: level from `fib_counter`; 1 means the next step would exceed the counter width.
- `step` output 1: one-cycle count enable to both counters.
- `clr` output 1: one-cycle synchronous clear to both counters.
- `state_o` output 2: current state (CLEAR=0, MANUAL=1, AUTO=2, HALT=3).

## Operation
States and their behaviour:
- **CLEAR**
  - `clr`=1 for exactly one cycle.
  - Next state is AUTO if `auto_en`=1, otherwise MANUAL.
  - Prescaler and period counter are zeroed.
- **MANUAL**
  - `but_pulse` produces `step` on the next cycle.
  - A rising edge of `auto_en` goes to CLEAR.
- **AUTO**
  - A base tick increments the period counter.
  - When the count reaches `div`, it wraps to 0 and produces `step`.
  - `but_pulse` toggles a pause flag; while paused, the prescaler holds and no steps are issued. The pause flag is cleared in CLEAR.
  - A falling edge of `auto_en` goes to CLEAR.
- **HALT**
  - Entered from MANUAL or AUTO when a step is due while `fib_ovf`=1. That step is suppressed.
  - No steps are issued.
  - Leaves only via `rst_req` or an `auto_en` edge, both of which go to CLEAR.

Priority within a cycle, highest first: `rst_n` low, then `rst_req`, then an `auto_en` edge, then `fib_ovf` on a due step, then `step`. `rst_req` in any state goes to CLEAR.

Arithmetic and width rules:
- `div` is sampled at each period wrap; a change takes effect from the next period.
- `div`=0 gives period 2^X.
- The prescaler is X bits and wraps naturally; its carry out is the base tick.
- The period counter is W bits and compares equal to `div`.
- Edge detection of `auto_en` uses one registered copy. That copy is loaded with the current `auto_en` during reset, so no false edge appears after reset.

## Timing
- Reset values:
  - state = CLEAR, so `clr`=1 and `state_o`=0 while `rst_n` is low.
  - `step`=0.
  - Prescaler, period counter and pause flag = 0.
- First cycle after `rst_n` rises: still CLEAR (`clr`=1). MANUAL or AUTO follows on the next cycle.
- `step` is registered: asserted in the cycle after the qualifying `but_pulse` or period wrap, and lasts one cycle.
- `clr` is a Moore output of CLEAR and lasts one cycle per entry.
- `step` and `clr` are never asserted in the same cycle. A `but_pulse` coincident with `rst_req` or an `auto_en` edge is dropped.
- `but_pulse` pulses in back-to-back cycles in MANUAL produce back-to-back `step` pulses.
- `fib_ovf` is sampled in the same cycle the step is due.

## Structure
- Shared package `fib_pkg`:
  - State encoding constants CLEAR, MANUAL, AUTO, HALT.
  - Default X and W.
- One sub-module, `tick_prescaler`: X-bit free-running counter with `en` (not paused) and synchronous `clr`. Outputs a one-cycle `tick` on wrap.
- The state machine, period counter and edge detection live in `fib_step_controller`.

## Test plan
All scenarios use X=2, so one base tick every 4 cycles.
- **Reset:** hold `rst_n`=0 for 3 cycles, then release with `auto_en`=0 -> `clr`=1 through the first cycle after release, then `state_o`=1, `step`=0.
- **Manual steps:** in MANUAL, 3 `but_pulse` pulses (two of them adjacent) -> exactly 3 `step` pulses, each one cycle after its click.
- **Auto period:** `auto_en` 0->1 with `div`=2 -> one `clr` cycle, then `step` every 12 cycles; change `div` to 0 mid-period -> the next period is still 12 cycles, later periods are 4.
- **Pause:** in AUTO, a `but_pulse` pauses stepping (no `step` for 40 cycles); a second `but_pulse` resumes, and the next `step` arrives after the remaining prescaler count.
- **Overflow:** hold `fib_ovf`=1 when a step is due -> no `step`, `state_o`=3; later `but_pulse` ignored; `rst_req` -> `clr` pulse, then MANUAL.
- **Simultaneous events:** `rst_req` and `but_pulse` in the same cycle -> `clr`, no `step`. `auto_en` falling together with a period wrap -> `clr`, no `step`, then MANUAL.
